dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning edges from request acceptance to ack_o high; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning log2 of storage depth in 32-bit words.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_i, input, 1, CPU memory-stage request valid.
REQ-006 SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port addr_i, input, 32, byte address.
REQ-008 SHALL have port wdata_i, input, 32, store data.
REQ-009 SHALL have port rdata_o, output, 32, load data, registered.
REQ-010 SHALL have port ack_o, output, 1, one-cycle completion pulse, registered.
REQ-011 SHALL have port err_o, output, 1, completion carries an error, valid only with ack_o.
REQ-012 SHALL have port stall_o, output, 1, pipeline freeze request to hazard logic.

Function
REQ-013 SHALL implement states IDLE, BUSY, RESP.
REQ-014 In IDLE with req_i=1, SHALL latch we_i, addr_i and wdata_i and go to RESP if LATENCY=1, else to BUSY with counter loaded to LATENCY-2.
REQ-015 In BUSY, SHALL decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-016 ack_o SHALL be 1 exactly while in RESP, i.e. for one cycle, LATENCY edges after the accepting edge.
REQ-017 From RESP, SHALL always go to IDLE; req_i high in the cycle after ack_o is a new request, accepted in that IDLE cycle.
REQ-018 Peak throughput SHALL be one request per LATENCY+1 cycles.
REQ-019 stall_o SHALL equal req_i AND NOT ack_o (combinational).
REQ-020 The CPU holds req_i, we_i, addr_i and wdata_i stable until ack_o; the responder uses only the latched copies, and completes the transaction even if req_i drops early.
REQ-021 Word index SHALL be latched addr[ADDR_W+1:2]; storage SHALL be 2^ADDR_W x 32 bits.
REQ-022 Request SHALL be an error if latched addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
REQ-023 A valid store SHALL write storage on the edge entering RESP; rdata_o SHALL be unchanged; err_o=0.
REQ-024 A valid load SHALL load rdata_o from storage on the edge entering RESP; err_o=0.
REQ-025 An error request SHALL NOT write storage; rdata_o SHALL be 0 and err_o=1 in RESP.
REQ-026 A load following a store to the same word SHALL return the stored data.
REQ-027 err_o SHALL be 0 whenever ack_o is 0.

Reset
REQ-028 rst_i=1 at an edge SHALL force state IDLE, counter 0, ack_o=0, err_o=0 and rdata_o=0, overriding all other inputs.
REQ-029 Reset mid-transaction (BUSY or RESP) SHALL abandon the transaction; a pending store SHALL NOT be written.
REQ-030 Storage contents SHALL NOT be altered by reset.
REQ-031 During and after reset, stall_o SHALL follow REQ-019, so req_i=1 stalls until a fresh transaction acks.

Verification
REQ-032 LATENCY=3; store addr 0x10, data 0xDEADBEEF -> ack_o high exactly 3 cycles after accept; stall_o=1 for those 3 cycles, 0 in the ack cycle; err_o=0.
REQ-033 Then load addr 0x10 -> rdata_o=0xDEADBEEF with ack_o; load addr 0x14, never written after a store of 0x12345678 there -> 0x12345678.
REQ-034 Load addr 0x11 (misaligned) and addr 0x80 (out of range, ADDR_W=5) -> ack_o and err_o=1 together, rdata_o=0; storage unchanged on re-read.
REQ-035 Back-to-back: req_i held high across 3 requests -> accepts in the cycle after each ack; acks spaced exactly 4 cycles apart.
REQ-036 Store to 0x20 with rst_i pulsed in BUSY -> no ack, outputs zeroed; a subsequent load of 0x20 returns the prior contents.
REQ-037 LATENCY=1 -> ack_o on the cycle immediately after accept; stall_o high for exactly 1 cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Fixed-latency data-memory responder for a CPU memory stage. A request is
//   accepted in IDLE, held for LATENCY edges, and completed with a one-cycle
//   ack_o pulse. Address or alignment errors complete with err_o instead of
//   touching storage.
//
// Ports
//   clk_i     single clock, rising edge
//   rst_i     synchronous active-high reset (storage contents are kept)
//   req_i     request valid from the memory stage
//   we_i      1 = store, 0 = load
//   addr_i    byte address
//   wdata_i   store data
//   rdata_o   load data (registered, 0 on error, held otherwise)
//   ack_o     one-cycle completion pulse (registered)
//   err_o     completion error flag, only meaningful with ack_o
//   stall_o   pipeline freeze: req_i & ~ack_o
//
// state | meaning
// IDLE  | waiting for req_i; the operand is latched on the accepting edge
// BUSY  | counting down the remaining latency
// RESP  | ack_o high for this single cycle
module dmem_responder #(
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    // Operand used on the edge that enters RESP. With LATENCY=1 that edge is
    // the accepting edge itself, so the live inputs are used; otherwise the
    // latched copy is used and req_i may already have dropped.
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-1:0] cur_idx;
    logic              cur_err;
    logic              enter_resp;

    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_we    = we_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
        end
        cur_idx    = cur_addr[ADDR_W+1:2];
        cur_err    = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_W + 2)) != 32'd0);
        enter_resp = ((state_q == IDLE) && req_i && (LATENCY == 1))
                  || ((state_q == BUSY) && (cnt_q == 4'd0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (enter_resp) begin
                ack_q <= 1'b1;
                err_q <= cur_err;
                if (cur_err) begin
                    rdata_q <= 32'd0;
                end else if (!cur_we) begin
                    rdata_q <= mem_q[cur_idx];
                end
            end
        end
    end

    // Storage has no reset; a reset on the completing edge cancels the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && cur_we && !cur_err) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign stall_o = req_i & ~ack_q;

endmodule
